// File: rtl/core_pkg.sv
// Shared core definitions: instruction width, HALT encoding and the
// instruction-memory FSM state type.
package core_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hE000;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        LOAD
    } imem_state_t;

endpackage

// File: rtl/instr_mem_ram.sv
// Simple 1W1R synchronous RAM with a registered read port.
// rdata holds its value in cycles where re is low.
module instr_mem_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: clear-on-reset, sequential valid/ready
// program load, and a single registered fetch port accepted only while idle.
module instr_mem_loadable
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned PC_W   = 16,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(HALT_WORD),
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [PC_W-1:0]   fetch_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              fetch_oob,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              mem_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_done
);

    // Wide enough to hold both any fetch address and the value DEPTH itself.
    localparam int unsigned CMP_W = (PC_W > ADDR_W + 1) ? PC_W : ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    imem_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic              fill_sel;
    logic [DATA_W-1:0] rdata;
    logic              oob;
    logic              accept;
    logic              re;
    logic              beat;
    logic              we;
    logic [DATA_W-1:0] wdata;

    assign oob    = CMP_W'(fetch_addr) >= CMP_W'(DEPTH);
    assign accept = fetch_en && mem_ready && !reset;
    assign re     = accept && !oob;

    // A beat coinciding with load_start is dropped: the restart wins.
    assign beat  = load_valid && load_ready && !load_start && !reset;
    assign we    = ((state == CLEAR) && !reset) || beat;
    assign wdata = (state == LOAD) ? load_data : FILL_WORD;

    instr_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ptr),
        .wdata (wdata),
        .re    (re),
        .raddr (fetch_addr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // fill_sel remembers whether the last accepted fetch (or reset) should
    // present FILL_WORD instead of the RAM output; the RAM holds rdata otherwise.
    assign instr_out = fill_sel ? FILL_WORD : rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            fetch_oob   <= 1'b0;
            fill_sel    <= 1'b1;
        end else begin
            instr_valid <= accept;
            fetch_oob   <= accept && oob;
            if (accept) begin
                fill_sel <= oob;
            end
        end
    end

    // load_count cannot exceed DEPTH: the load always terminates at LAST_ADDR.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            ptr        <= '0;
            mem_ready  <= 1'b0;
            load_ready <= 1'b0;
            load_count <= '0;
            load_done  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            unique case (state)
                CLEAR: begin
                    ptr <= ptr + PTR_ONE;
                    if (ptr == LAST_ADDR) begin
                        ptr       <= '0;
                        state     <= IDLE;
                        mem_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        load_count <= '0;
                        mem_ready  <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        ptr        <= '0;
                        load_count <= '0;
                    end else if (beat) begin
                        ptr        <= ptr + PTR_ONE;
                        load_count <= load_count + CNT_ONE;
                        if (load_last || (ptr == LAST_ADDR)) begin
                            state      <= IDLE;
                            load_ready <= 1'b0;
                            mem_ready  <= 1'b1;
                            load_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= CLEAR;
                    ptr        <= '0;
                    mem_ready  <= 1'b0;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: clear, load, overflow, out-of-range,
// fetch/load overlap, restart and mid-load reset.
module tb_instr_mem_loadable;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PC_W   = 16;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [15:0] HALT   = 16'hE000;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_en;
    logic [PC_W-1:0]   fetch_addr;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              fetch_oob;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              mem_ready;
    logic [ADDR_W:0]   load_count;
    logic              load_done;

    always #5 clk = ~clk;

    instr_mem_loadable #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .PC_W      (PC_W),
        .FILL_WORD (HALT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fetch_oob   (fetch_oob),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .mem_ready   (mem_ready),
        .load_count  (load_count),
        .load_done   (load_done)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        oob;
    } fetch_vec_t;

    fetch_vec_t vec [9];
    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [15:0] exp_data,
                         input logic exp_oob, input string tag);
        fetch_en   = 1'b1;
        fetch_addr = a;
        step();
        fetch_en = 1'b0;
        check($sformatf("%s_valid@%0h", tag, a), 32'(instr_valid), 32'd1);
        check($sformatf("%s_data@%0h", tag, a), 32'(instr_out), 32'(exp_data));
        check($sformatf("%s_oob@%0h", tag, a), 32'(fetch_oob), 32'(exp_oob));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!mem_ready && n < 4 * DEPTH) begin
            step();
            n++;
        end
        check($sformatf("%s_mem_ready", tag), 32'(mem_ready), 32'd1);
        check($sformatf("%s_clear_cycles", tag), 32'(n), 32'(DEPTH));
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        repeat (2) step();

        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_fetch_oob",   32'(fetch_oob),   32'd0);
        check("rst_instr_out",   32'(instr_out),   32'(HALT));
        check("rst_mem_ready",   32'(mem_ready),   32'd0);
        check("rst_load_ready",  32'(load_ready),  32'd0);
        check("rst_load_done",   32'(load_done),   32'd0);
        check("rst_load_count",  32'(load_count),  32'd0);
        reset = 1'b0;
        wait_ready("t1");

        // Test 1: whole memory cleared to HALT
        for (int a = 0; a < int'(DEPTH); a++) begin
            fetch(16'(a), HALT, 1'b0, "t1");
        end

        // Test 2: short program with load_last
        vec[0] = '{16'd0, 16'h1F9C, 1'b0};
        vec[1] = '{16'd1, 16'h407A, 1'b0};
        vec[2] = '{16'd2, 16'h1A66, 1'b0};
        vec[3] = '{16'd3, HALT,     1'b0};
        start_load();
        check("t2_load_ready", 32'(load_ready), 32'd1);
        check("t2_mem_ready",  32'(mem_ready),  32'd0);
        send_beat(16'h1F9C, 1'b0);
        send_beat(16'h407A, 1'b0);
        check("t2_done_early", 32'(load_done), 32'd0);
        send_beat(16'h1A66, 1'b1);
        check("t2_load_done",  32'(load_done),  32'd1);
        check("t2_load_count", 32'(load_count), 32'd3);
        check("t2_mem_ready2", 32'(mem_ready),  32'd1);
        check("t2_ready_off",  32'(load_ready), 32'd0);
        step();
        check("t2_done_pulse", 32'(load_done),  32'd0);
        check("t2_count_hold", 32'(load_count), 32'd3);
        for (int i = 0; i < 4; i++) begin
            fetch(vec[i].addr, vec[i].data, vec[i].oob, "t2");
        end

        // Test 3: overflow without load_last
        start_load();
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            check($sformatf("t3_load_ready_%0d", i), 32'(load_ready), 32'(i < int'(DEPTH)));
            send_beat(16'(32'h8000 + i), 1'b0);
            if (i == int'(DEPTH) - 1) begin
                check("t3_load_done",  32'(load_done),  32'd1);
                check("t3_load_count", 32'(load_count), 32'(DEPTH));
            end
        end
        check("t3_count_sat", 32'(load_count), 32'(DEPTH));
        check("t3_done_low",  32'(load_done),  32'd0);

        // Tests 3/4: last word, out-of-range and return to in-range
        vec[4] = '{16'(DEPTH - 1), 16'h803F, 1'b0};
        vec[5] = '{16'd0,          16'h8000, 1'b0};
        vec[6] = '{16'(DEPTH),     HALT,     1'b1};
        vec[7] = '{16'hFFFF,       HALT,     1'b1};
        vec[8] = '{16'(DEPTH - 1), 16'h803F, 1'b0};
        for (int i = 4; i < 9; i++) begin
            fetch(vec[i].addr, vec[i].data, vec[i].oob, "t4");
        end
        step();
        check("t4_idle_valid", 32'(instr_valid), 32'd0);
        check("t4_idle_oob",   32'(fetch_oob),   32'd0);
        check("t4_idle_hold",  32'(instr_out),   32'h803F);

        // Test 5: fetch with load_start, fetch during LOAD, restart
        fetch_en   = 1'b1;
        fetch_addr = 16'd0;
        load_start = 1'b1;
        step();
        fetch_en   = 1'b0;
        load_start = 1'b0;
        check("t5_old_valid", 32'(instr_valid), 32'd1);
        check("t5_old_data",  32'(instr_out),   32'h8000);
        check("t5_in_load",   32'(load_ready),  32'd1);
        check("t5_not_ready", 32'(mem_ready),   32'd0);
        fetch_en   = 1'b1;
        fetch_addr = 16'd1;
        load_valid = 1'b1;
        load_data  = 16'h2222;
        step();
        fetch_en = 1'b0;
        check("t5_load_fetch_valid", 32'(instr_valid), 32'd0);
        check("t5_load_fetch_hold",  32'(instr_out),   32'h8000);
        load_start = 1'b1;
        load_data  = 16'h3333;
        step();
        load_start = 1'b0;
        load_valid = 1'b0;
        check("t5_restart_count", 32'(load_count), 32'd0);
        check("t5_restart_ready", 32'(load_ready), 32'd1);
        send_beat(16'h4444, 1'b1);
        check("t5_load_done",  32'(load_done),  32'd1);
        check("t5_load_count", 32'(load_count), 32'd1);
        fetch(16'd0, 16'h4444, 1'b0, "t5");
        fetch(16'd1, 16'h8001, 1'b0, "t5");
        fetch(16'd2, 16'h8002, 1'b0, "t5");

        // Test 6: reset in the middle of a load
        start_load();
        send_beat(16'h5555, 1'b0);
        send_beat(16'h6666, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_load_ready", 32'(load_ready),  32'd0);
        check("t6_mem_ready",  32'(mem_ready),   32'd0);
        check("t6_load_count", 32'(load_count),  32'd0);
        check("t6_valid",      32'(instr_valid), 32'd0);
        check("t6_instr_out",  32'(instr_out),   32'(HALT));
        wait_ready("t6");
        fetch(16'd0, HALT, 1'b0, "t6");
        fetch(16'd1, HALT, 1'b0, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
